address_issue_ctrl: RTL
=======================

# address_issue_ctrl

Issue controller and result-port arbiter for the address add functional unit. It accepts address instructions 020 and 021 (octal) from instruction issue, checks the A-register scoreboard for hazards, and drives operand read addresses plus the instruction to the fixed-latency add unit. It tracks every in-flight result to writeback, and arbitrates the single A-register write port between add-unit results and external A-register loads.

## Interface
- size, 32: A-register width (informational; no datapath passes through this block)
- nreg, 8: number of A registers; address width is 3
- lat, 2: add-unit latency, in cycles from o_FuValid to result valid
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- i_IssValid  in  1  issue request valid
- o_IssReady  out  1  issue request accepted this cycle
- i_Instr  in  7  opcode
- i_I / i_J / i_K  in  3 each  destination Ai and sources Aj, Ak
- o_IllegalOp  out  1  one-cycle pulse: a non-020/021 opcode was consumed
- o_FuValid  out  1  operation launched into the add unit
- o_FuInstr  out  7  opcode to the add unit
- o_RdJ / o_RdK  out  3 each  A-file read addresses for Aj, Ak
- i_LdValid  in  1  external load write request
- i_LdAddr  in  3  load destination register
- o_LdReady  out  1  load accepted this cycle
- o_WrEn  out  1  A-file write enable
- o_WrAddr  out  3  A-file write address
- o_WrSel  out  1  write data select: 0 = add unit, 1 = load data
- o_Busy  out  nreg  scoreboard reservation bits

## Operation
- **Opcodes:**
  - Legal opcodes are 7'o020 and 7'o021.
  - Any other opcode is consumed whenever i_IssValid is high and rst is low, with no hazard check.
  - It pulses o_IllegalOp in the following cycle, launches nothing and reserves nothing.
- **Hazards for a legal opcode:** the request stalls (o_IssReady = 0) if any of o_Busy[J], o_Busy[K] or o_Busy[I] is set (RAW and WAW).
- **Accept:** a legal opcode is accepted when there is no hazard and rst is low.
- **Acceptance at cycle T:**
  - o_Busy[I] is set from T+1.
  - o_FuValid, o_FuInstr, o_RdJ and o_RdK are registered and valid at T+1 only.
  - The destination tag enters a lat-deep shift pipe.
- **Writeback:**
  - At T+1+lat: o_WrEn = 1, o_WrAddr = I, o_WrSel = 0.
  - o_Busy[I] is cleared at the end of that cycle (clear from T+2+lat).
  - A register in its writeback cycle still reads as busy.
- **Load acceptance:** o_LdReady = i_LdValid & ~rst & ~busy[LdAddr] & no add-unit writeback due next cycle & not (issue accepted this cycle with I, J or K == LdAddr).
  - Issue has priority over loads.
- **Accepted load at T:**
  - o_Busy[LdAddr] is set for T+1 only.
  - o_WrEn = 1, o_WrAddr = LdAddr, o_WrSel = 1 at T+1.
- The write port never carries two writes in one cycle. Add-unit results are never delayed; loads always yield.
- Throughput is one issue per cycle when there are no hazards. Up to lat+1 operations may be in flight.
- **Reset:**
  - rst high clears o_Busy, the tag pipe and all registered outputs.
  - o_IssReady and o_LdReady are 0 while rst is high.
  - In-flight operations are discarded: no o_WrEn occurs after reset for operations issued before it.

## Timing
- All outputs reset to 0.
- o_IssReady and o_LdReady are combinational from current inputs and state.
- All other outputs are registered.
- Add issue to writeback is 1+lat cycles (default 3). Issue to o_FuValid is 1 cycle.
- Load acceptance to write is 1 cycle.
- Earliest dependent issue: a consumer of Ai issued at T can issue at T+2+lat.
  - Aj == Ak == Ai is allowed. It checks and reserves one register.
- Issue with I == J in the same instruction is legal. Only the prior busy state is checked.

## Test plan
- **Back-to-back issue:** 020 I=1,J=2,K=3 at cycle 0, then 021 I=4,J=5,K=6 at cycle 1 -> o_FuValid at 1 and 2; o_WrEn addr 1 at 3 and addr 4 at 4; o_Busy=0 at 5.
- **RAW stall:** 020 I=1 at 0, then 020 J=1 -> o_IssReady low in cycles 1-3, accepted at 4, o_RdJ=1 at 5.
- **Port conflict:** 020 I=2 at 0; load LdAddr=5 requested at 2 -> o_LdReady=0 at 2 (writeback due at 3); accepted at 3, written at 4 with o_WrSel=1.
- **Same-cycle issue/load collision:** issue J=7 and load LdAddr=7 both at 0 -> issue accepted, load stalled one cycle, load written at 2.
- **Illegal opcode:** opcode 7'o022 -> o_IllegalOp pulse next cycle; no o_FuValid, no busy bit, no o_WrEn.
- **Reset mid-operation:** rst high at cycle 2 with two operations in flight -> o_Busy=0 at 3, no o_WrEn afterwards; a new issue after rst drops behaves as the first scenario.

Source files
------------

// File: rtl/address_issue_ctrl.sv
// Issue control and A-register write-port arbitration for the address add unit.
// Tracks A-register reservations and in-flight destination tags through to writeback.
`timescale 1ns/1ps
module address_issue_ctrl #(
  parameter int unsigned size = 32,
  parameter int unsigned nreg = 8,
  parameter int unsigned lat  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_IssValid,
  output logic                    o_IssReady,
  input  logic [6:0]              i_Instr,
  input  logic [$clog2(nreg)-1:0] i_I,
  input  logic [$clog2(nreg)-1:0] i_J,
  input  logic [$clog2(nreg)-1:0] i_K,
  output logic                    o_IllegalOp,
  output logic                    o_FuValid,
  output logic [6:0]              o_FuInstr,
  output logic [$clog2(nreg)-1:0] o_RdJ,
  output logic [$clog2(nreg)-1:0] o_RdK,
  input  logic                    i_LdValid,
  input  logic [$clog2(nreg)-1:0] i_LdAddr,
  output logic                    o_LdReady,
  output logic                    o_WrEn,
  output logic [$clog2(nreg)-1:0] o_WrAddr,
  output logic                    o_WrSel,
  output logic [nreg-1:0]         o_Busy
);

  localparam int unsigned AW = $clog2(nreg);

  if (size == 0 || lat == 0) begin : g_param_check
    $error("address_issue_ctrl: size and lat must be nonzero");
  end

  logic          legal;
  logic          hazard;
  logic          iss_go;
  logic          ld_conflict;
  logic [nreg-1:0] busy_nxt;

  // Destination tags of operations in flight through the add unit.
  logic [lat-1:0] pipe_v;
  logic [AW-1:0]  pipe_a [lat];

  always_comb begin
    legal       = (i_Instr == 7'o020) || (i_Instr == 7'o021);
    hazard      = o_Busy[i_I] | o_Busy[i_J] | o_Busy[i_K];
    o_IssReady  = i_IssValid & ~rst & (~legal | ~hazard);
    iss_go      = o_IssReady & legal;
    ld_conflict = iss_go & ((i_I == i_LdAddr) | (i_J == i_LdAddr) | (i_K == i_LdAddr));
    // A pending add-unit writeback owns next cycle's write port.
    o_LdReady   = i_LdValid & ~rst & ~o_Busy[i_LdAddr] & ~pipe_v[lat-1] & ~ld_conflict;
  end

  // Set and clear never target the same bit: both requesters require the bit clear,
  // while a register in its writeback cycle still reads busy.
  always_comb begin
    busy_nxt = o_Busy;
    if (o_WrEn)
      busy_nxt[o_WrAddr] = 1'b0;
    if (iss_go)
      busy_nxt[i_I] = 1'b1;
    if (o_LdReady)
      busy_nxt[i_LdAddr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_Busy      <= '0;
      o_IllegalOp <= 1'b0;
      o_FuValid   <= 1'b0;
      o_FuInstr   <= '0;
      o_RdJ       <= '0;
      o_RdK       <= '0;
      o_WrEn      <= 1'b0;
      o_WrAddr    <= '0;
      o_WrSel     <= 1'b0;
      pipe_v      <= '0;
      for (int unsigned n = 0; n < lat; n++)
        pipe_a[n] <= '0;
    end else begin
      o_Busy      <= busy_nxt;
      o_IllegalOp <= o_IssReady & ~legal;
      o_FuValid   <= iss_go;
      o_FuInstr   <= iss_go ? i_Instr : '0;
      o_RdJ       <= iss_go ? i_J : '0;
      o_RdK       <= iss_go ? i_K : '0;
      pipe_v[0]   <= iss_go;
      pipe_a[0]   <= i_I;
      for (int unsigned n = 1; n < lat; n++) begin
        pipe_v[n] <= pipe_v[n-1];
        pipe_a[n] <= pipe_a[n-1];
      end
      o_WrEn   <= pipe_v[lat-1] | o_LdReady;
      o_WrSel  <= ~pipe_v[lat-1] & o_LdReady;
      o_WrAddr <= pipe_v[lat-1] ? pipe_a[lat-1] : (o_LdReady ? i_LdAddr : '0);
    end
  end

endmodule
